// File: rtl/sv_stream_arbiter_if.sv
// Stream bundle shared by the round-robin arbiter and its environment.
// master: the arbiter's view (accepts requester beats, drives the output beat); slave: the environment's view.
interface sv_stream_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       s_valid;
  logic [N_REQ-1:0]       s_ready;
  logic [N_REQ*WIDTH-1:0] s_data;
  logic [N_REQ-1:0]       s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [WIDTH-1:0]       m_data;
  logic                   m_last;
  logic [IDX_W-1:0]       m_grant;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_grant
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_grant
  );
endinterface

// File: rtl/sv_stream_arbiter.sv
// Round-robin arbiter funnelling N_REQ valid/ready streams into one registered output beat.
// Define SV_ARB_PKT_LOCK_EN to hold each grant until the requester's last beat; otherwise grants rotate every beat.
module sv_stream_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input logic                 clk,
  input logic                 rst_n,
  sv_stream_arbiter_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_gnt;
  logic [IDX_W-1:0] w_gnt_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_gnt_inc;
  logic             w_any;
  logic             w_load_ok;
  logic             w_xfer;
  logic             w_release;
  logic [N_REQ-1:0] w_s_ready;
  logic [WIDTH-1:0] w_sel_data;

  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_last;
  logic [IDX_W-1:0] r_m_grant;

  // Scan from ptr upward (wrapping); descending k lets the nearest valid requester win.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    w_pick = r_ptr;
    w_any  = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % N_REQ;
      if (bus.s_valid[idx]) begin
        w_pick = IDX_W'(idx);
        w_any  = 1'b1;
      end
    end
  end

  assign w_load_ok  = !r_m_valid || bus.m_ready;
  assign w_xfer     = (r_state == BUSY) && bus.s_valid[r_gnt] && w_load_ok;
  assign w_sel_data = bus.s_data[int'(r_gnt)*WIDTH +: WIDTH];
  assign w_gnt_inc  = (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

`ifdef SV_ARB_PKT_LOCK_EN
  assign w_release = w_xfer && bus.s_last[r_gnt];
`else
  assign w_release = w_xfer;
`endif

  always_comb begin
    w_s_ready = '0;
    if (r_state == BUSY) begin
      w_s_ready[r_gnt] = w_load_ok;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_pick;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_ptr_nxt   = w_gnt_inc;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Output register: a load wins over a drain so back-to-back beats keep m_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_grant <= '0;
    end else if (w_xfer) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_sel_data;
      r_m_last  <= bus.s_last[r_gnt];
      r_m_grant <= r_gnt;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_last  = r_m_last;
  assign bus.m_grant = r_m_grant;

endmodule

// File: tb/tb_sv_stream_arbiter.sv
// Bench for sv_stream_arbiter: directed latency/wrap/reset checks, then randomized rounds scored against a queue model.
module tb_sv_stream_arbiter;

  localparam int N = 4;
  localparam int W = 32;
`ifdef SV_ARB_PKT_LOCK_EN
  localparam bit PKT_MODE = 1'b1;
`else
  localparam bit PKT_MODE = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    logic [1:0]   g;
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   sb_en = 1'b0;

  beat_t dq[N][$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  sv_stream_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  sv_stream_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected beat whenever the output handshake will complete.
  initial begin : monitor
    exp_t         e;
    bit           prev_stall;
    logic [W+2:0] prev_v;
    prev_stall = 1'b0;
    prev_v     = '0;
    forever begin
      @(negedge clk);
      #2;
      if (sb_en && rst_n) begin
        if (prev_stall) begin
          total++;
          if ({bus.m_data, bus.m_last, bus.m_grant} !== prev_v) begin
            bad++;
            $display("FAIL hold: got %0h expected %0h", {bus.m_data, bus.m_last, bus.m_grant}, prev_v);
          end
        end
        if (bus.m_valid && !bus.m_ready) begin
          total++;
          if (bus.s_ready !== '0) begin
            bad++;
            $display("FAIL stall_sready: got %0b expected 0", bus.s_ready);
          end
        end
        if (bus.m_valid && bus.m_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_beat: got grant=%0d data=%0h, expected no beat", bus.m_grant, bus.m_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.m_grant !== e.g || bus.m_data !== e.d || bus.m_last !== e.l) begin
              bad++;
              $display("FAIL beat: got g=%0d d=%0h l=%0b expected g=%0d d=%0h l=%0b",
                       bus.m_grant, bus.m_data, bus.m_last, e.g, e.d, e.l);
            end
          end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_v     = {bus.m_data, bus.m_last, bus.m_grant};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Reference: whole output order computed from the queues with plain round-robin rules.
  task automatic build_round();
    beat_t b;
    exp_t  e;
    beat_t mq[N][$];
    int    ptr, g, pending, npk, len;
    pending = 0;
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      npk = int'($urandom_range(0, 3));
      for (int p = 0; p < npk; p++) begin
        len = int'($urandom_range(1, 4));
        for (int k = 0; k < len; k++) begin
          b.d = $urandom;
          b.l = (k == len - 1);
          dq[i].push_back(b);
          mq[i].push_back(b);
          pending++;
        end
      end
    end
    ptr = 0;
    while (pending > 0) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && mq[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
      do begin
        b = mq[g].pop_front();
        e.g = 2'(g);
        e.d = b.d;
        e.l = b.l;
        exp_q.push_back(e);
        pending--;
      end while (PKT_MODE && !b.l);
      ptr = (g + 1) % N;
    end
  endtask

  task automatic run_round(input int stall_at);
    logic [N-1:0] fire;
    bit           done;
    fire = '0;
    done = 1'b0;
    for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (fire[i] && dq[i].size() > 0) dq[i].delete(0);
      for (int i = 0; i < N; i++) begin
        bus.s_valid[i] = (dq[i].size() > 0);
        if (dq[i].size() > 0) begin
          bus.s_data[i*W +: W] = dq[i][0].d;
          bus.s_last[i]        = dq[i][0].l;
        end else begin
          bus.s_data[i*W +: W] = $urandom;
          bus.s_last[i]        = 1'($urandom_range(0, 1));
        end
      end
      bus.m_ready = (cyc >= stall_at && cyc < stall_at + 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      fire = bus.s_valid & bus.s_ready;
      #2;
      if (exp_q.size() == 0) done = 1'b1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL round_timeout: got %0d beats left, expected 0", exp_q.size());
      exp_q.delete();
    end
    bus.s_valid = '0;
    bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n       = 1'b0;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 64'(bus.m_valid), 0);
    chk("rst_m_data",  64'(bus.m_data),  0);
    chk("rst_m_last",  64'(bus.m_last),  0);
    chk("rst_m_grant", 64'(bus.m_grant), 0);
    chk("rst_s_ready", 64'(bus.s_ready), 0);

    // Single requester 2: ready at cycle 1, beat out at cycle 2.
    rst_n = 1'b1;
    bus.s_valid = 4'b0100;
    bus.s_last  = 4'b0100;
    bus.s_data[2*W +: W] = 32'hA5A5_0001;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("lat_ready_c1", 64'(bus.s_ready), 64'b0100);
    chk("lat_mvalid_c1", 64'(bus.m_valid), 0);
    @(negedge clk);
    chk("lat_mvalid_c2", 64'(bus.m_valid), 1);
    chk("lat_mdata_c2",  64'(bus.m_data),  64'hA5A5_0001);
    chk("lat_mgrant_c2", 64'(bus.m_grant), 2);
    chk("lat_mlast_c2",  64'(bus.m_last),  1);
    chk("idle_sready",   64'(bus.s_ready), 0);

    // ptr is now 3: requester 3 beats requester 0, then ptr wraps to 0.
    bus.s_valid = 4'b1001;
    bus.s_last  = 4'b1001;
    bus.s_data[0*W +: W] = 32'h1111_0000;
    bus.s_data[3*W +: W] = 32'h3333_0000;
    @(negedge clk);
    chk("ptr3_ready", 64'(bus.s_ready), 64'b1000);
    @(negedge clk);
    chk("ptr3_grant", 64'(bus.m_grant), 3);
    chk("ptr3_data",  64'(bus.m_data),  64'h3333_0000);
    bus.s_valid = 4'b0001;
    @(negedge clk);
    chk("wrap_ready", 64'(bus.s_ready), 64'b0001);
    @(negedge clk);
    chk("wrap_grant", 64'(bus.m_grant), 0);
    chk("wrap_data",  64'(bus.m_data),  64'h1111_0000);
    bus.s_valid = '0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a packet from requester 1.
    bus.s_valid = 4'b0010;
    bus.s_last  = 4'b0000;
    bus.s_data[1*W +: W] = 32'h0000_0010;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 4'b1010;
    @(negedge clk);
    chk("midrst_m_valid", 64'(bus.m_valid), 0);
    chk("midrst_s_ready", 64'(bus.s_ready), 0);
    chk("midrst_m_grant", 64'(bus.m_grant), 0);
    chk("midrst_m_data",  64'(bus.m_data),  0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rearb", 64'(bus.s_ready), 64'b0010);
    bus.s_last = 4'b0010;
    @(negedge clk);
    chk("midrst_beat_grant", 64'(bus.m_grant), 1);
    bus.s_valid = '0;
    bus.s_last  = '0;
    repeat (2) @(negedge clk);

    // Randomized rounds, each starting from reset so the model's ptr starts at 0.
    for (int r = 0; r < 8; r++) begin
      rst_n = 1'b0;
      bus.s_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      build_round();
      sb_en = 1'b1;
      run_round(int'($urandom_range(4, 20)));
      sb_en = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sv_stream_arbiter.md
# sv_stream_arbiter

Round-robin arbiter that shares one registered output stage between `N_REQ` valid/ready stream requesters. It sits in front of the downstream pipeline register, grants one requester at a time, and forwards that requester's beats through a single output register with full backpressure. Grants are packet-granular (held until `last`) or beat-granular, depending on compile-time configuration.

## Interface
- `N_REQ`, 4: number of requesters, at least 2.
- `WIDTH`, 32: data width per beat.
- `IDX_W`, `$clog2(N_REQ)`: grant index width (derived; do not override).

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `s_valid`  in  N_REQ  per-requester beat valid.
- `s_ready`  out  N_REQ  per-requester beat accept.
- `s_data`  in  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- `s_last`  in  N_REQ  per-requester end-of-packet flag.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  output beat data.
- `m_last`  out  1  output end-of-packet flag.
- `m_grant`  out  IDX_W  index of the requester that sourced the beat in the output register.

## Operation
- State machine `IDLE`/`BUSY`, plus grant register `gnt` and priority pointer `ptr`.
- IDLE:
  - If any `s_valid` is high, select the first requester with `s_valid` high, scanning from `ptr` upward modulo `N_REQ`.
  - Register it into `gnt` and go to BUSY.
  - `s_ready` is all-zero in IDLE.
- BUSY:
  - `s_ready[gnt] = !m_valid || m_ready`; all other `s_ready` bits are 0.
  - A transfer occurs when `s_valid[gnt] && s_ready[gnt]`.
  - On a transfer, the output register loads `s_data` slice, `s_last`, and `m_grant <= gnt`, and `m_valid` goes to 1.
- Release condition: a transfer with `s_last[gnt] = 1` (see Configuration).
  - On release: `ptr <= (gnt+1) mod N_REQ`, then return to IDLE.
- Output register:
  - `m_valid` clears when `m_ready && m_valid` and no new transfer occurs that cycle.
  - A simultaneous drain and load keeps `m_valid = 1` with the new beat.
- While BUSY, gaps in `s_valid[gnt]` hold the grant. Other requesters wait regardless of their `s_valid`.

## Timing
- Reset values:
  - `m_valid=0`, `m_data=0`, `m_last=0`, `m_grant=0`, `s_ready=0`.
  - State IDLE, `ptr=0`, `gnt=0`.
- First-beat latency: `s_valid` seen in IDLE at cycle 0 → `s_ready` high at cycle 1 → `m_valid` high at cycle 2.
- Within a packet, throughput is 1 beat/cycle while `m_ready=1`. Each arbitration costs exactly one idle cycle.
- `m_data`, `m_last`, `m_grant` are stable while `m_valid && !m_ready`.
- `s_ready` depends combinationally on `m_ready`. No combinational path runs from `s_valid` to `s_ready`.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` (wrapping) wins. `ptr` wraps from `N_REQ-1` to 0.
- Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle with the updated `ptr`.
- Reset asserted mid-packet:
  - All state returns to reset values on that edge, and the output beat in flight is discarded.
  - Re-arbitration starts from `ptr=0`.

## Configuration
- `SV_ARB_PKT_LOCK_EN` defined: release occurs only on a transfer with `s_last[gnt]=1`, so multi-beat packets are never interleaved.
- Not defined: release occurs on every transfer, giving per-beat round-robin with one idle cycle per beat. `s_last` is still forwarded to `m_last` unchanged.

## Test plan
- Single requester:
  - Stimulus: after reset, `s_valid[2]=1` with `s_data=0xA5A5_0001`, `s_last=1`, `m_ready=1`.
  - Required: `s_ready[2]` high at cycle 1; `m_valid=1`, `m_data=0xA5A5_0001`, `m_grant=2` at cycle 2; `ptr=3` afterwards.
- Round-robin fairness:
  - Stimulus: all four requesters hold single-beat packets with `s_last=1`, `m_ready=1`.
  - Required: `m_grant` sequence is 0,1,2,3,0, with one idle cycle between beats.
- Packet lock (macro defined):
  - Stimulus: requester 1 sends a 4-beat packet 0x10–0x13 with `last` on the final beat; requester 0 requests from cycle 1.
  - Required: `m_data` is 0x10,0x11,0x12,0x13 contiguous with `m_grant=1`; requester 0 is granted only after that.
- Backpressure:
  - Stimulus: `m_ready=0` for 5 cycles mid-packet.
  - Required: `m_data`, `m_last`, `m_grant` stay constant; `s_ready[gnt]=0` while `m_valid=1`; no beat is lost or duplicated after `m_ready=1`.
- Beat mode (macro undefined):
  - Stimulus: requesters 0 and 1 each hold 3-beat packets.
  - Required: `m_grant` alternates 0,1,0,1,0,1.
- Reset mid-packet:
  - Stimulus: drop `rst_n` for one cycle during beat 2 of 4.
  - Required: next cycle `m_valid=0`, `s_ready=0`, `m_grant=0`; the subsequent grant goes to the lowest valid requester.
